muldiv_unit: RTL and testbench

//   Iterative RV64M/RV32M multiply/divide unit alongside the single-cycle ALU in execute.

---
 rtl/muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with request and result valid/ready handshakes.
// Operands are reduced to magnitudes; the result sign is applied on the last BUSY step.
module muldiv_unit #(
   parameter int Xlen         = 64,
   parameter int BitsPerCycle = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      funct3_i,
   input  logic            op32_i,
   input  logic [Xlen-1:0] a_i,
   input  logic [Xlen-1:0] b_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [Xlen-1:0] res_o
);
   localparam int              CntW   = $clog2(Xlen / BitsPerCycle) + 1;
   localparam logic [Xlen-1:0] Ones   = {Xlen{1'b1}};
   localparam logic [Xlen-1:0] Zero   = {Xlen{1'b0}};
   localparam logic [Xlen-1:0] MinX   = {1'b1, {(Xlen-1){1'b0}}};
   localparam logic [Xlen-1:0] MinW   = Ones << 31;
   localparam logic [Xlen-1:0] Mask32 = Ones >> (Xlen - 32);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   function automatic logic [Xlen-1:0] sext32(input logic [Xlen-1:0] v, input logic word);
      logic [Xlen-1:0] r;
      r = v;
      if (word) begin
         for (int i = 32; i < Xlen; i++) r[i] = v[31];
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t            r_state;
   logic              r_ready, r_valid;
   logic [Xlen-1:0]   r_res;
   logic [CntW-1:0]   r_cnt, r_last;
   logic              r_div, r_word, r_neg, r_rem_neg, r_hi, r_rem;
   logic [2*Xlen-1:0] r_acc, r_x;
   logic [Xlen-1:0]   r_y;

   logic              w_word, w_div, w_a_sgn, w_b_sgn, w_neg_a, w_neg_b;
   logic              w_illegal, w_b_zero, w_ovf, w_fast;
   logic [Xlen-1:0]   w_a_ext, w_b_ext, w_mag_a, w_mag_b, w_fast_res;
   logic [CntW-1:0]   w_last;
   logic [2*Xlen-1:0] w_acc_nxt, w_x_nxt, w_prod;
   logic [Xlen-1:0]   w_y_nxt, w_q, w_r, w_raw, w_fin;

   // Decode the incoming request: operand extension, magnitudes and fast-path detection.
   always_comb begin
      w_word  = (Xlen == 64) && op32_i;
      w_div   = funct3_i[2];
      w_a_sgn = (funct3_i == 3'd1) || (funct3_i == 3'd2) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
      w_b_sgn = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
      if (w_word) begin
         w_a_ext = w_a_sgn ? sext32(a_i, 1'b1) : (a_i & Mask32);
         w_b_ext = w_b_sgn ? sext32(b_i, 1'b1) : (b_i & Mask32);
         w_last  = CntW'(32 / BitsPerCycle - 1);
      end else begin
         w_a_ext = a_i;
         w_b_ext = b_i;
         w_last  = CntW'(Xlen / BitsPerCycle - 1);
      end
      w_neg_a    = w_a_sgn && w_a_ext[Xlen-1];
      w_neg_b    = w_b_sgn && w_b_ext[Xlen-1];
      w_mag_a    = w_neg_a ? (Zero - w_a_ext) : w_a_ext;
      w_mag_b    = w_neg_b ? (Zero - w_b_ext) : w_b_ext;
      w_illegal  = w_word && !w_div && (funct3_i[1:0] != 2'd0);
      w_b_zero   = w_div && (w_b_ext == Zero);
      w_ovf      = w_div && !funct3_i[0] && (w_a_ext == (w_word ? MinW : MinX)) && (w_b_ext == Ones);
      w_fast     = w_illegal || w_b_zero || w_ovf;
      if (w_illegal) begin
         w_fast_res = Zero;
      end else if (w_b_zero) begin
         w_fast_res = funct3_i[1] ? sext32(w_a_ext, w_word) : Ones;
      end else if (w_ovf) begin
         w_fast_res = funct3_i[1] ? Zero : sext32(w_a_ext, w_word);
      end else begin
         w_fast_res = Zero;
      end
   end

   // One BUSY step: BitsPerCycle shift-add or restoring-divide iterations.
   always_comb begin
      logic [2*Xlen-1:0] v_acc;
      logic [Xlen:0]     v_rem;
      logic [Xlen-1:0]   v_y;
      v_acc = r_acc;
      v_rem = r_acc[Xlen:0];
      v_y   = r_y;
      if (r_div) begin
         for (int j = 0; j < BitsPerCycle; j++) begin
            v_rem = {v_rem[Xlen-1:0], v_y[Xlen-1]};
            v_y   = {v_y[Xlen-2:0], 1'b0};
            if (v_rem >= {1'b0, r_x[Xlen-1:0]}) begin
               v_rem  = v_rem - {1'b0, r_x[Xlen-1:0]};
               v_y[0] = 1'b1;
            end else begin
               v_y[0] = 1'b0;
            end
         end
         w_acc_nxt = {{(Xlen-1){1'b0}}, v_rem};
         w_x_nxt   = r_x;
         w_y_nxt   = v_y;
      end else begin
         for (int j = 0; j < BitsPerCycle; j++) begin
            if (r_y[j]) begin
               v_acc = v_acc + (r_x << j);
            end else begin
               v_acc = v_acc;
            end
         end
         w_acc_nxt = v_acc;
         w_x_nxt   = r_x << BitsPerCycle;
         w_y_nxt   = r_y >> BitsPerCycle;
      end
   end

   // Final result: sign fix-up, half selection and word sign extension.
   always_comb begin
      w_prod = r_neg ? ({(2*Xlen){1'b0}} - w_acc_nxt) : w_acc_nxt;
      w_q    = r_neg ? (Zero - w_y_nxt) : w_y_nxt;
      w_r    = r_rem_neg ? (Zero - w_acc_nxt[Xlen-1:0]) : w_acc_nxt[Xlen-1:0];
      if (r_div) begin
         w_raw = r_rem ? w_r : w_q;
      end else begin
         w_raw = r_hi ? w_prod[2*Xlen-1:Xlen] : w_prod[Xlen-1:0];
      end
      w_fin = sext32(w_raw, r_word);
   end

   // Control FSM with registered handshake outputs and result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_ready   <= 1'b1;
         r_valid   <= 1'b0;
         r_res     <= Zero;
         r_cnt     <= {CntW{1'b0}};
         r_last    <= {CntW{1'b0}};
         r_div     <= 1'b0;
         r_word    <= 1'b0;
         r_neg     <= 1'b0;
         r_rem_neg <= 1'b0;
         r_hi      <= 1'b0;
         r_rem     <= 1'b0;
         r_acc     <= {(2*Xlen){1'b0}};
         r_x       <= {(2*Xlen){1'b0}};
         r_y       <= Zero;
      end else begin
         case (r_state)
            IDLE: begin
               if (valid_i) begin
                  r_cnt     <= {CntW{1'b0}};
                  r_last    <= w_last;
                  r_div     <= w_div;
                  r_word    <= w_word;
                  r_neg     <= w_neg_a ^ w_neg_b;
                  r_rem_neg <= w_neg_a;
                  r_hi      <= (funct3_i[1:0] != 2'd0);
                  r_rem     <= funct3_i[1];
                  r_acc     <= {(2*Xlen){1'b0}};
                  r_x       <= {Zero, (w_div ? w_mag_b : w_mag_a)};
                  r_y       <= w_div ? (w_word ? (w_mag_a << (Xlen - 32)) : w_mag_a) : w_mag_b;
                  r_ready   <= 1'b0;
                  if (w_fast) begin
                     r_res   <= w_fast_res;
                     r_valid <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= BUSY;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            BUSY: begin
               r_acc <= w_acc_nxt;
               r_x   <= w_x_nxt;
               r_y   <= w_y_nxt;
               r_cnt <= r_cnt + CntW'(1);
               if (r_cnt == r_last) begin
                  r_res   <= w_fin;
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_state <= BUSY;
               end
            end
            DONE: begin
               if (ready_i) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_state <= DONE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ready_o = r_ready;
   assign valid_o = r_valid;
   assign res_o   = r_res;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (Xlen=64, BitsPerCycle=1): vector table plus corner sequences.
module tb_muldiv_unit;
   logic        clk_i, rst_i, valid_i, ready_o, op32_i, valid_o, ready_i;
   logic [2:0]  funct3_i;
   logic [63:0] a_i, b_i, res_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] sb_q[$];

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic        o32;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;
   vec_t vecs[$];

   muldiv_unit #(.Xlen(64), .BitsPerCycle(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .funct3_i(funct3_i), .op32_i(op32_i), .a_i(a_i), .b_i(b_i),
      .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input string n, input logic [2:0] f, input logic o, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] e, input int l);
      vec_t v;
      v.name = n; v.f3 = f; v.o32 = o; v.a = a; v.b = b; v.exp = e; v.lat = l;
      vecs.push_back(v);
   endtask

   // Accept one request and record its expected result; inputs are scrambled afterwards.
   task automatic send(input logic [2:0] f, input logic o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] e);
      int guard;
      guard = 0;
      while (!ready_o && guard < 200) begin
         @(posedge clk_i); #1; guard++;
      end
      funct3_i = f; op32_i = o; a_i = a; b_i = b; valid_i = 1'b1;
      @(posedge clk_i);
      sb_q.push_back(e);
      #1;
      valid_i  = 1'b0;
      a_i      = {$urandom, $urandom};
      b_i      = {$urandom, $urandom};
      funct3_i = 3'($urandom_range(0, 7));
      op32_i   = ~o;
   endtask

   task automatic wait_done(output int lat, output logic rdy_seen);
      lat = 1;
      rdy_seen = 1'b0;
      while (!valid_o && lat < 200) begin
         if (ready_o) rdy_seen = 1'b1;
         @(posedge clk_i); #1; lat++;
      end
      if (ready_o) rdy_seen = 1'b1;
   endtask

   task automatic consume(input string name);
      logic [63:0] e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_sb actual queue size 0 required 1", name);
      end else begin
         e = sb_q.pop_front();
         chk({name, "_res"}, res_o, e);
      end
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      chk({name, "_idle"}, {62'd0, valid_o, ready_o}, 64'd1);
   endtask

   task automatic do_op(input vec_t v);
      int   lat;
      logic rdy;
      send(v.f3, v.o32, v.a, v.b, v.exp);
      wait_done(lat, rdy);
      chk({v.name, "_lat"}, 64'(lat), 64'(v.lat));
      chk({v.name, "_rdy_busy"}, {63'd0, rdy}, 64'd0);
      consume(v.name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   lat;
      logic rdy;
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
      funct3_i = 3'd0; op32_i = 1'b0; a_i = 64'd0; b_i = 64'd0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_ready", {63'd0, ready_o}, 64'd1);
      chk("reset_valid", {63'd0, valid_o}, 64'd0);
      chk("reset_res", res_o, 64'd0);
      rst_i = 1'b0;

      add("mul_7_m3",    3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      add("mul_big",     3'd0, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 65);
      add("mulhu_ones",  3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      add("mulhu_pow",   3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65);
      add("mulhsu_m1_2", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      add("mulh_m1_m1",  3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
      add("div_m7_2",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      add("rem_m7_2",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      add("div_7_m2",    3'd4, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      add("rem_7_m2",    3'd6, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
      add("div_min_1",   3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 65);
      add("divu_100_7",  3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
      add("remu_100_7",  3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
      add("divu_by0",    3'd5, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      add("remu_by0",    3'd7, 1'b0, 64'd123, 64'd0, 64'd123, 1);
      add("rem_by0",     3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
      add("div_ovf",     3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      add("rem_ovf",     3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      add("divuw",       3'd5, 1'b1, 64'h1_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
      add("mulw",        3'd0, 1'b1, 64'hDEAD_0000_0000_0003, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 33);
      add("remw_m7_2",   3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      add("remuw",       3'd7, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 33);
      add("divw_by0",    3'd4, 1'b1, 64'h55, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      add("divw_ovf",    3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
      add("mulhw_ill",   3'd1, 1'b1, 64'd5, 64'd5, 64'd0, 1);
      add("mulhuw_ill",  3'd3, 1'b1, 64'd1, 64'd1, 64'd0, 1);

      for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

      // Result held for 10 cycles while the consumer stalls.
      send(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      wait_done(lat, rdy);
      chk("hold_lat", 64'(lat), 64'd65);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         chk("hold_hs", {62'd0, valid_o, ready_o}, 64'd2);
         chk("hold_res", res_o, 64'hFFFF_FFFF_FFFF_FFFD);
      end
      consume("hold");

      // Requests offered while BUSY must be ignored.
      send(3'd5, 1'b1, 64'h1_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000);
      repeat (5) @(posedge clk_i);
      #1;
      funct3_i = 3'd0; op32_i = 1'b0; a_i = 64'd2; b_i = 64'd3; valid_i = 1'b1;
      rdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         if (ready_o) rdy = 1'b1;
      end
      valid_i = 1'b0;
      chk("busy_noaccept_rdy", {63'd0, rdy}, 64'd0);
      wait_done(lat, rdy);
      chk("busy_lat", 64'(lat) + 64'd15, 64'd33);
      consume("busy");
      repeat (3) @(posedge clk_i);
      #1;
      chk("busy_not_stored", {62'd0, valid_o, ready_o}, 64'd1);
      chk("busy_sb_empty", 64'(sb_q.size()), 64'd0);

      // Asynchronous reset in the middle of a multiply.
      send(3'd0, 1'b0, 64'd5, 64'd6, 64'd30);
      repeat (10) @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      chk("rst_mid_valid", {63'd0, valid_o}, 64'd0);
      chk("rst_mid_ready", {63'd0, ready_o}, 64'd1);
      chk("rst_mid_res", res_o, 64'd0);
      sb_q.delete();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      begin
         vec_t v;
         v.name = "after_rst"; v.f3 = 3'd0; v.o32 = 1'b0; v.a = 64'd5; v.b = 64'd6;
         v.exp = 64'd30; v.lat = 65;
         do_op(v);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
